data_mem_access: RTL and testbench
==================================

# data_mem_access

Initiator for the data-RAM port used by the MIPS core and its memory test models. Takes one load/store request at a time from the core's memory stage and turns it into word-aligned `data_read`/`data_write` cycles. Handles big-endian byte-lane mapping, sign/zero extension and read-modify-write for sub-word stores, since the RAM has no byte enables. Also reports alignment errors and returns the load result with a one-cycle response pulse.

## Interface
- No parameters.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present; accepted when `req_valid && req_ready`.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; all others are illegal.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data (rt); also the old rt value for LWL/LWR merges.
- `resp_valid`  out  1  one-cycle pulse when the request completes.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_error`  out  1  misaligned or illegal op, valid with `resp_valid`.
- `data_address`  out  32  `{addr[31:2],2'b00}` of the latched request.
- `data_read`  out  1  read strobe; RAM read data is combinational.
- `data_write`  out  1  single-cycle write strobe.
- `data_writedata`  out  32  word written, in memory byte order.
- `data_readdata`  in  32  word read, in memory byte order.

## Operation
- Byte-lane rule: the byte at offset k (k = addr[1:0]) is `data_readdata[8k+7:8k]`. Logical big-endian word = byte-reversed `data_readdata`. Writes apply the same mapping in reverse.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: on accept, latch op, address and wdata, then check legality.
  - LH/LHU/SH need addr[0]=0.
  - LW/SW need addr[1:0]=0.
  - Illegal or misaligned request goes to RESP with error set and no memory strobe.
- Loads: IDLE→READ→RESP.
  - READ drives `data_read=1` and captures the extended result.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- SW: IDLE→WRITE→RESP. WRITE drives `data_write=1` with the byte-reversed wdata.
- SB/SH: IDLE→READ→WRITE→RESP.
  - READ captures the old word.
  - WRITE stores the old word with only the addressed lane(s) replaced: SH at offset 0 → lanes 0,1; offset 2 → lanes 2,3.
- LWL at offset k: result = logical bytes k..3 in the upper bytes, old rt in the lower k bytes.
- LWR at offset k: result = old rt in the upper 3−k bytes, logical bytes 0..k in the lower bytes.
- RESP: `resp_valid=1` for one cycle, then IDLE.
- `data_read` and `data_write` are never high in the same cycle. At most one strobe cycle of each kind per request.

## Timing
- Reset (asynchronous, any state): state IDLE. All outputs 0 except `req_ready`=1. The latched request is discarded.
- Reset during WRITE removes `data_write` immediately, so no partial write occurs.
- `req_ready` is 0 from the cycle after accept until the cycle after RESP.
- `resp_valid` latency after the accept edge:
  - errors: 1 cycle.
  - LW/LB/LH/LBU/LHU/LWL/LWR/SW: 2 cycles.
  - SB/SH: 3 cycles.
- `data_address` is held stable through READ and WRITE. It is 0 in IDLE.
- `resp_rdata`/`resp_error` are valid only while `resp_valid`=1, and 0 otherwise.

## Configuration
- `UNALIGNED_LWLR_EN`
  - Defined: LWL/LWR are supported as above. They are never flagged misaligned.
  - Undefined: ops 5 and 6 are illegal and respond with `resp_error`=1 after 1 cycle, with no memory access.

## Test plan
- RAM word 0 preloaded with `data_readdata` 0x78563412. LW addr 0 → `resp_rdata` 0x12345678, 2 cycles, one `data_read` pulse.
- RAM word 1 stored 0xAC68EEEE (logical 0xEEEE68AC):
  - LB addr 4 → 0xFFFFFFEE.
  - LBU addr 4 → 0x000000EE.
  - LH addr 6 → 0x000068AC.
  - LH addr 4 → 0xFFFFEEEE.
- SB addr 2, wdata 0x000000AB, over word 0 → one `data_write` with `data_writedata` 0x78AB3412; `resp_valid` 3 cycles after accept.
- LW addr 2 and SH addr 1 → `resp_error`=1 after 1 cycle; `data_read`/`data_write` never asserted.
- With `UNALIGNED_LWLR_EN`, word 0, wdata 0xAABBCCDD:
  - LWL addr 1 → 0x345678DD.
  - LWR addr 1 → 0xAABB1234.
  - Without the macro, both → error.
- Assert `reset_n`=0 during the WRITE cycle of SB → `data_write` drops immediately, the RAM word is unchanged, and `req_ready`=1.

Source files
------------

// File: rtl/data_mem_access.sv
// Load/store initiator for a data RAM without byte enables: big-endian lane mapping, sign/zero
// extension and read-modify-write for SB/SH. Define UNALIGNED_LWLR_EN to build LWL/LWR support.
module data_mem_access (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);
    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    // Store data already placed in memory lane order, plus which lanes it replaces.
    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] word;
    } st_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic is_legal(input logic [3:0] op, input logic [1:0] off);
        logic ok;
        case (op)
            OP_LB, OP_LBU, OP_SB: ok = 1'b1;
            OP_LH, OP_LHU, OP_SH: ok = ~off[0];
            OP_LW, OP_SW:         ok = (off == 2'b00);
`ifdef UNALIGNED_LWLR_EN
            OP_LWL, OP_LWR:       ok = 1'b1;
`endif
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_subword_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] rd);
        logic [4:0]        bsel;
        logic [4:0]        hsel_hi;
        logic [4:0]        hsel_lo;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]       res;
        bsel    = {off, 3'b000};
        hsel_hi = {off[1], 4'b0000};
        hsel_lo = {off[1], 4'b1000};
        b = rd[bsel +: 8];
        // The lower-addressed lane is the more significant byte of a halfword.
        h = {rd[hsel_hi +: 8], rd[hsel_lo +: 8]};
        case (op)
            OP_LB:   res = 32'(b);
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = 32'(h);
            OP_LHU:  res = {16'd0, h};
            OP_LW:   res = bswap32(rd);
            default: res = 32'd0;
        endcase
        return res;
    endfunction

`ifdef UNALIGNED_LWLR_EN
    function automatic logic [31:0] lwl_merge(input logic [1:0] off, input logic [31:0] lw,
                                              input logic [31:0] rt);
        logic [4:0]  sh;
        logic [31:0] keep;
        sh   = {off, 3'b000};
        keep = ~(32'hFFFF_FFFF << sh);
        return (lw << sh) | (rt & keep);
    endfunction

    function automatic logic [31:0] lwr_merge(input logic [1:0] off, input logic [31:0] lw,
                                              input logic [31:0] rt);
        logic [4:0]  sh;
        logic [31:0] keep;
        sh   = 5'd24 - {off, 3'b000};
        keep = ~(32'hFFFF_FFFF >> sh);
        return (lw >> sh) | (rt & keep);
    endfunction
`endif

    function automatic st_t store_lanes(input logic [3:0] op, input logic [1:0] off,
                                        input logic [31:0] wd);
        st_t st;
        st.mask = 4'd0;
        st.word = 32'd0;
        case (op)
            OP_SB: begin
                st.mask[off]                  = 1'b1;
                st.word[{off, 3'b000} +: 8]   = wd[7:0];
            end
            OP_SH: begin
                st.mask[{off[1], 1'b0}]       = 1'b1;
                st.mask[{off[1], 1'b1}]       = 1'b1;
                st.word[{off[1], 4'b0000} +: 8] = wd[15:8];
                st.word[{off[1], 4'b1000} +: 8] = wd[7:0];
            end
            OP_SW: begin
                st.mask = 4'hF;
                st.word = bswap32(wd);
            end
            default: begin
                st.mask = 4'd0;
                st.word = 32'd0;
            end
        endcase
        return st;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] rd, input st_t st);
        logic [31:0] m;
        m = {{8{st.mask[3]}}, {8{st.mask[2]}}, {8{st.mask[1]}}, {8{st.mask[0]}}};
        return (rd & ~m) | (st.word & m);
    endfunction

    state_t      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic [31:0] data_address_q;
    logic        data_read_q;
    logic        data_write_q;
    logic [31:0] data_writedata_q;

    logic [3:0]  op_q;
    logic [1:0]  off_q;
    st_t         st_q;
`ifdef UNALIGNED_LWLR_EN
    logic [31:0] rt_q;
`endif

    logic        accept;
    logic        legal_d;
    st_t         st_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;

    assign accept = req_valid && req_ready_q;

    always_comb begin
        legal_d = is_legal(req_op, req_addr[1:0]);
        st_d    = store_lanes(req_op, req_addr[1:0], req_wdata);
        merge_d = merge_word(data_readdata, st_q);
        load_d  = load_result(op_q, off_q, data_readdata);
`ifdef UNALIGNED_LWLR_EN
        if (op_q == OP_LWL) begin
            load_d = lwl_merge(off_q, bswap32(data_readdata), rt_q);
        end else if (op_q == OP_LWR) begin
            load_d = lwr_merge(off_q, bswap32(data_readdata), rt_q);
        end
`endif
    end

    // Request payload needs no reset: it is only consulted after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= req_op;
            off_q <= req_addr[1:0];
            st_q  <= st_d;
`ifdef UNALIGNED_LWLR_EN
            rt_q  <= req_wdata;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'd0;
            resp_error_q     <= 1'b0;
            data_address_q   <= 32'd0;
            data_read_q      <= 1'b0;
            data_write_q     <= 1'b0;
            data_writedata_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        if (!legal_d) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                        end else if (req_op == OP_SW) begin
                            state_q          <= S_WRITE;
                            data_write_q     <= 1'b1;
                            data_address_q   <= {req_addr[31:2], 2'b00};
                            data_writedata_q <= st_d.word;
                        end else begin
                            state_q        <= S_READ;
                            data_read_q    <= 1'b1;
                            data_address_q <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                S_READ: begin
                    data_read_q <= 1'b0;
                    if (is_subword_store(op_q)) begin
                        state_q          <= S_WRITE;
                        data_write_q     <= 1'b1;
                        data_writedata_q <= merge_d;
                    end else begin
                        state_q        <= S_RESP;
                        resp_valid_q   <= 1'b1;
                        resp_rdata_q   <= load_d;
                        data_address_q <= 32'd0;
                    end
                end
                S_WRITE: begin
                    state_q          <= S_RESP;
                    data_write_q     <= 1'b0;
                    data_writedata_q <= 32'd0;
                    data_address_q   <= 32'd0;
                    resp_valid_q     <= 1'b1;
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    resp_error_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_error     = resp_error_q;
    assign data_address   = data_address_q;
    assign data_read      = data_read_q;
    assign data_write     = data_write_q;
    assign data_writedata = data_writedata_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: byte-addressed reference memory with per-cycle strobe/response checks.
module tb_data_mem_access;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram      [0:63];
    logic [7:0] init_mem [0:63];
    logic [7:0] shm      [0:63];
    logic       init_en;

`ifdef UNALIGNED_LWLR_EN
    localparam bit LWLR = 1'b1;
`else
    localparam bit LWLR = 1'b0;
`endif

    data_mem_access dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    always #5 clk = ~clk;

    assign data_readdata = {ram[{data_address[5:2], 2'd3}], ram[{data_address[5:2], 2'd2}],
                            ram[{data_address[5:2], 2'd1}], ram[{data_address[5:2], 2'd0}]};

    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_mem[i];
        end else if (data_write) begin
            ram[{data_address[5:2], 2'd0}] <= data_writedata[7:0];
            ram[{data_address[5:2], 2'd1}] <= data_writedata[15:8];
            ram[{data_address[5:2], 2'd2}] <= data_writedata[23:16];
            ram[{data_address[5:2], 2'd3}] <= data_writedata[31:24];
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge after it returns to idle.
    task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input bit lit_en, input logic [31:0] lit_rdata, input logic lit_err);
        logic [5:0]  a;
        logic [5:0]  w;
        int          k;
        int          kind;
        int          lat;
        logic [31:0] er;
        logic [31:0] ew;
        logic [31:0] wbase;
        logic        ee;
        logic        x_rd;
        logic        x_wr;
        logic        x_rv;
        a = addr[5:0];
        w = {a[5:2], 2'b00};
        k = int'(a[1:0]);
        // kind: 0 error, 1 load, 2 word store, 3 sub-word store
        case (op)
            4'd0, 4'd1: kind = 1;
            4'd2, 4'd3: kind = a[0] ? 0 : 1;
            4'd4:       kind = (k == 0) ? 1 : 0;
            4'd5, 4'd6: kind = LWLR ? 1 : 0;
            4'd8:       kind = 3;
            4'd9:       kind = a[0] ? 0 : 3;
            4'd10:      kind = (k == 0) ? 2 : 0;
            default:    kind = 0;
        endcase
        lat = (kind == 0) ? 1 : ((kind == 3) ? 3 : 2);
        ee  = (kind == 0);
        er  = 32'd0;
        ew  = 32'd0;
        if (kind == 1) begin
            case (op)
                4'd0: er = {{24{shm[a][7]}}, shm[a]};
                4'd1: er = {24'd0, shm[a]};
                4'd2: er = {{16{shm[a][7]}}, shm[a], shm[a + 1]};
                4'd3: er = {16'd0, shm[a], shm[a + 1]};
                4'd4: er = {shm[w], shm[w + 1], shm[w + 2], shm[w + 3]};
                4'd5: begin
                    er = wd;
                    for (int i = k; i < 4; i++) er[31 - 8 * (i - k) -: 8] = shm[w + i];
                end
                4'd6: begin
                    er = wd;
                    for (int i = 0; i <= k; i++) er[8 * (k - i) +: 8] = shm[w + i];
                end
                default: er = 32'd0;
            endcase
        end
        if (kind >= 2) begin
            case (op)
                4'd8: shm[a] = wd[7:0];
                4'd9: begin
                    shm[a]     = wd[15:8];
                    shm[a + 1] = wd[7:0];
                end
                default: begin
                    shm[w]     = wd[31:24];
                    shm[w + 1] = wd[23:16];
                    shm[w + 2] = wd[15:8];
                    shm[w + 3] = wd[7:0];
                end
            endcase
            ew = {shm[w + 3], shm[w + 2], shm[w + 1], shm[w]};
        end
        wbase = {addr[31:2], 2'b00};

        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (c <= lat) begin
                req_valid = 1'($urandom_range(0, 1));
                req_op    = 4'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            x_rd = ((kind == 1) || (kind == 3)) && (c == 1);
            x_wr = ((kind == 2) && (c == 1)) || ((kind == 3) && (c == 2));
            x_rv = (c == lat);
            chk1("data_read", data_read, x_rd);
            chk1("data_write", data_write, x_wr);
            chk1("resp_valid", resp_valid, x_rv);
            chk1("req_ready", req_ready, c == lat + 1);
            if (x_rd || x_wr) chk32("data_address", data_address, wbase);
            if (c == lat + 1) chk32("idle_address", data_address, 32'd0);
            if (x_wr) chk32("data_writedata", data_writedata, ew);
            if (x_rv) begin
                chk32("resp_rdata", resp_rdata, er);
                chk1("resp_error", resp_error, ee);
                if (lit_en) begin
                    chk32("lit_rdata", resp_rdata, lit_rdata);
                    chk1("lit_error", resp_error, lit_err);
                end
            end else begin
                chk32("rdata_quiet", resp_rdata, 32'd0);
                chk1("error_quiet", resp_error, 1'b0);
            end
        end
        chk32("ram_word", {ram[w + 3], ram[w + 2], ram[w + 1], ram[w]},
              {shm[w + 3], shm[w + 2], shm[w + 1], shm[w]});
    endtask

    initial begin
        reset_n   = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        init_en   = 1'b1;
        for (int i = 0; i < 64; i++) init_mem[i] = 8'($urandom);
        init_mem[0] = 8'h12; init_mem[1] = 8'h34; init_mem[2] = 8'h56; init_mem[3] = 8'h78;
        init_mem[4] = 8'hEE; init_mem[5] = 8'hEE; init_mem[6] = 8'h68; init_mem[7] = 8'hAC;
        for (int i = 0; i < 64; i++) shm[i] = init_mem[i];

        #2 reset_n = 1'b0;
        #1;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk32("rst_resp_rdata", resp_rdata, 32'd0);
        chk1("rst_resp_error", resp_error, 1'b0);
        chk32("rst_data_address", data_address, 32'd0);
        chk1("rst_data_read", data_read, 1'b0);
        chk1("rst_data_write", data_write, 1'b0);
        chk32("rst_data_writedata", data_writedata, 32'd0);
        repeat (2) @(negedge clk);
        init_en = 1'b0;
        reset_n = 1'b1;
        chk1("idle_ready", req_ready, 1'b1);

        do_req(4'd4, 32'd0, 32'd0, 1'b1, 32'h12345678, 1'b0);
        do_req(4'd0, 32'd4, 32'd0, 1'b1, 32'hFFFFFFEE, 1'b0);
        do_req(4'd1, 32'd4, 32'd0, 1'b1, 32'h000000EE, 1'b0);
        do_req(4'd2, 32'd6, 32'd0, 1'b1, 32'h000068AC, 1'b0);
        do_req(4'd2, 32'd4, 32'd0, 1'b1, 32'hFFFFEEEE, 1'b0);
`ifdef UNALIGNED_LWLR_EN
        do_req(4'd5, 32'd1, 32'hAABBCCDD, 1'b1, 32'h345678DD, 1'b0);
        do_req(4'd6, 32'd1, 32'hAABBCCDD, 1'b1, 32'hAABB1234, 1'b0);
`else
        do_req(4'd5, 32'd1, 32'hAABBCCDD, 1'b1, 32'd0, 1'b1);
        do_req(4'd6, 32'd1, 32'hAABBCCDD, 1'b1, 32'd0, 1'b1);
`endif
        do_req(4'd8, 32'd2, 32'h000000AB, 1'b1, 32'd0, 1'b0);
        chk32("sb_word0", {ram[3], ram[2], ram[1], ram[0]}, 32'h78AB3412);
        do_req(4'd4, 32'd2, 32'd0, 1'b1, 32'd0, 1'b1);
        do_req(4'd9, 32'd1, 32'h1234, 1'b1, 32'd0, 1'b1);

        // Reset landing in the WRITE cycle of an SB must abort the write.
        req_valid = 1'b1;
        req_op    = 4'd8;
        req_addr  = 32'd0;
        req_wdata = 32'h00000011;
        @(negedge clk);
        req_valid = 1'b0;
        chk1("abort_read", data_read, 1'b1);
        @(negedge clk);
        chk1("abort_write_pre", data_write, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("abort_write_drop", data_write, 1'b0);
        chk1("abort_ready", req_ready, 1'b1);
        chk1("abort_read_low", data_read, 1'b0);
        chk1("abort_resp", resp_valid, 1'b0);
        chk32("abort_address", data_address, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk32("abort_word0", {ram[3], ram[2], ram[1], ram[0]}, 32'h78AB3412);
        chk1("abort_idle_ready", req_ready, 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [3:0]  op;
            logic [31:0] ad;
            int          r;
            int          gap;
            r = $urandom_range(0, 23);
            case (r)
                16: op = 4'd0;
                17: op = 4'd2;
                18: op = 4'd4;
                19: op = 4'd8;
                20: op = 4'd9;
                21: op = 4'd10;
                22: op = 4'd5;
                23: op = 4'd6;
                default: op = 4'(r);
            endcase
            ad = $urandom;
            if ($urandom_range(0, 2) == 0) ad[1:0] = 2'b00;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk1("gap_ready", req_ready, 1'b1);
                chk1("gap_resp", resp_valid, 1'b0);
                chk1("gap_read", data_read, 1'b0);
                chk1("gap_write", data_write, 1'b0);
            end
            do_req(op, ad, $urandom, 1'b0, 32'd0, 1'b0);
        end

        for (int i = 0; i < 64; i += 4) begin
            chk32("final_word", {ram[i + 3], ram[i + 2], ram[i + 1], ram[i]},
                  {shm[i + 3], shm[i + 2], shm[i + 1], shm[i]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
